// File: rtl/branch_stall_unit_if.sv
// Signal bundle between the ID-stage hazard detector and the pipeline control.
// STALL_PERF_CNT_EN adds the StallCycles counter output.
interface branch_stall_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_Branch;
    logic              id_UseRa;
    logic              id_UseRb;
    logic [REG_AW-1:0] id_Ra;
    logic [REG_AW-1:0] id_Rb;
    logic [REG_AW-1:0] ex_Rw;
    logic              ex_RegWr;
    logic              ex_MemtoReg;
    logic [REG_AW-1:0] mem_Rw;
    logic              mem_RegWr;
    logic              mem_MemtoReg;
    logic              Stall;
    logic              Bubble;
    logic              StallState;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0]  StallCycles;

    modport master (
        output id_Branch, id_UseRa, id_UseRb, id_Ra, id_Rb,
        output ex_Rw, ex_RegWr, ex_MemtoReg, mem_Rw, mem_RegWr, mem_MemtoReg,
        input  Stall, Bubble, StallState, StallCycles
    );

    modport slave (
        input  id_Branch, id_UseRa, id_UseRb, id_Ra, id_Rb,
        input  ex_Rw, ex_RegWr, ex_MemtoReg, mem_Rw, mem_RegWr, mem_MemtoReg,
        output Stall, Bubble, StallState, StallCycles
    );
`else
    modport master (
        output id_Branch, id_UseRa, id_UseRb, id_Ra, id_Rb,
        output ex_Rw, ex_RegWr, ex_MemtoReg, mem_Rw, mem_RegWr, mem_MemtoReg,
        input  Stall, Bubble, StallState
    );

    modport slave (
        input  id_Branch, id_UseRa, id_UseRb, id_Ra, id_Rb,
        input  ex_Rw, ex_RegWr, ex_MemtoReg, mem_Rw, mem_RegWr, mem_MemtoReg,
        output Stall, Bubble, StallState
    );
`endif
endinterface

// File: rtl/branch_stall_unit.sv
// ID-stage stall generator for hazards MEM->ID forwarding cannot cover.
// Define STALL_PERF_CNT_EN to add a saturating stall-cycle counter.
module branch_stall_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_stall_unit_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic              w_stall;
    logic              w_need1;
    logic              w_need2;
    logic              w_ex_m;
    logic              w_mem_m;
    logic [REG_AW-1:0] w_src [2];
    logic [1:0]        w_use;
    logic [1:0]        w_ex_hit;
    logic [1:0]        w_mem_hit;

    assign w_src[0] = bus.id_Ra;
    assign w_src[1] = bus.id_Rb;
    assign w_use    = {bus.id_UseRb, bus.id_UseRa};

    // Register 0 is hardwired, so a write to it is never a real producer.
    for (genvar gi = 0; gi < 2; gi++) begin : g_match
        assign w_ex_hit[gi]  = bus.ex_RegWr & (bus.ex_Rw != ZERO_REG) &
                               (bus.ex_Rw == w_src[gi]) & w_use[gi];
        assign w_mem_hit[gi] = bus.mem_RegWr & (bus.mem_Rw != ZERO_REG) &
                               (bus.mem_Rw == w_src[gi]) & w_use[gi];
    end

    assign w_ex_m  = |w_ex_hit;
    assign w_mem_m = |w_mem_hit;

    assign w_need2 = bus.id_Branch & bus.ex_MemtoReg & w_ex_m;
    assign w_need1 = (bus.id_Branch & ~bus.ex_MemtoReg & w_ex_m) |
                     (bus.id_Branch & bus.mem_MemtoReg & w_mem_m) |
                     (~bus.id_Branch & bus.ex_MemtoReg & w_ex_m);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load feeding a branch from EX needs a guaranteed second cycle; HOLD
    // provides it without re-evaluating the (by then bubbled) EX stage.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_need1 | w_need2;
                if (w_need2) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_stall      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_stall      = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.Stall      = w_stall;
    assign bus.Bubble     = w_stall;
    assign bus.StallState = (r_state == HOLD);

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign bus.StallCycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_branch_stall_unit.sv
// Directed self-checking bench for branch_stall_unit (both feature builds).
module tb_branch_stall_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    branch_stall_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    branch_stall_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic br, input logic ua, input logic ub,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] exrw, input logic exwr, input logic exld,
                         input logic [4:0] memrw, input logic memwr, input logic memld);
        bus.id_Branch    = br;
        bus.id_UseRa     = ua;
        bus.id_UseRb     = ub;
        bus.id_Ra        = ra;
        bus.id_Rb        = rb;
        bus.ex_Rw        = exrw;
        bus.ex_RegWr     = exwr;
        bus.ex_MemtoReg  = exld;
        bus.mem_Rw       = memrw;
        bus.mem_RegWr    = memwr;
        bus.mem_MemtoReg = memld;
    endtask

    task automatic clear_in();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_in();
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.StallState !== 1'b0 || bus.Stall !== 1'b0 || bus.Bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%b stall=%b bubble=%b required 0 0 0",
                     bus.StallState, bus.Stall, bus.Bubble);
        end
`ifdef STALL_PERF_CNT_EN
        n_tests++;
        if (bus.StallCycles !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d required 0", bus.StallCycles);
        end
`endif
        $display("[TB] test_reset: state=%b stall=%b", bus.StallState, bus.Stall);
        step();
    endtask

    task automatic test_load_branch();
        do_reset();
        // lw r5 in EX, beq on r5 in ID
        drive(1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1 || bus.Bubble !== 1'b1 || bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_br_c0: stall=%b bubble=%b state=%b required 1 1 0",
                     bus.Stall, bus.Bubble, bus.StallState);
        end
        step();
        // bubble now in EX, load in MEM; HOLD ignores inputs
        drive(1, 1, 0, 5, 0, 0, 0, 0, 5, 1, 1);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1 || bus.Bubble !== 1'b1 || bus.StallState !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_br_c1: stall=%b bubble=%b state=%b required 1 1 1",
                     bus.Stall, bus.Bubble, bus.StallState);
        end
        step();
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0 || bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_br_c2: stall=%b state=%b required 0 0",
                     bus.Stall, bus.StallState);
        end
`ifdef STALL_PERF_CNT_EN
        n_tests++;
        if (bus.StallCycles !== 4'd2) begin
            n_fail++;
            $display("FAIL ld_br_cnt: got %0d required 2", bus.StallCycles);
        end
`endif
        $display("[TB] test_load_branch: released stall=%b", bus.Stall);
        step();
    endtask

    task automatic test_alu_branch();
        do_reset();
        drive(1, 0, 1, 0, 7, 7, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1 || bus.Bubble !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_br_ex: stall=%b bubble=%b required 1 1", bus.Stall, bus.Bubble);
        end
        step();
        n_tests++;
        if (bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_br_state: got %b required 0", bus.StallState);
        end
        drive(1, 0, 1, 0, 7, 0, 0, 0, 7, 1, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_br_mem: stall=%b required 0", bus.Stall);
        end
        $display("[TB] test_alu_branch: done");
        step();
    endtask

    task automatic test_mem_load_branch();
        do_reset();
        drive(1, 1, 0, 3, 0, 0, 0, 0, 3, 1, 1);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mem_ld_br: stall=%b required 1", bus.Stall);
        end
        step();
        n_tests++;
        if (bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_ld_br_state: got %b required 0", bus.StallState);
        end
        drive(1, 1, 0, 3, 0, 0, 0, 0, 3, 1, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_alu_br: stall=%b required 0", bus.Stall);
        end
        $display("[TB] test_mem_load_branch: done");
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 1, 0, 4, 0, 4, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1 || bus.Bubble !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use: stall=%b bubble=%b required 1 1", bus.Stall, bus.Bubble);
        end
        step();
        n_tests++;
        if (bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_state: got %b required 0", bus.StallState);
        end
        drive(0, 1, 0, 4, 0, 4, 1, 0, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_use: stall=%b required 0", bus.Stall);
        end
        step();
        // mem load feeding a non-branch is covered by forwarding
        drive(0, 1, 0, 4, 0, 0, 0, 0, 4, 1, 1);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_load_use: stall=%b required 0", bus.Stall);
        end
        $display("[TB] test_load_use: done");
        step();
    endtask

    task automatic test_reg_zero();
        do_reset();
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_ex_load: stall=%b required 0", bus.Stall);
        end
        step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_mem_load: stall=%b required 0", bus.Stall);
        end
        step();
        drive(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_load_use: stall=%b required 0", bus.Stall);
        end
        step();
        // matching register but source not used
        drive(1, 0, 0, 9, 9, 9, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL unused_src: stall=%b required 0", bus.Stall);
        end
        $display("[TB] test_reg_zero: done");
        step();
    endtask

    task automatic test_dual_and_precedence();
        do_reset();
        // Ra == Rb both matching a load in EX: still exactly two cycles
        drive(1, 1, 1, 8, 8, 8, 1, 1, 0, 0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_c0: stall=%b required 1", bus.Stall);
        end
        step();
        clear_in();
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1 || bus.StallState !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_c1: stall=%b state=%b required 1 1", bus.Stall, bus.StallState);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b0 || bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_c2: stall=%b state=%b required 0 0", bus.Stall, bus.StallState);
        end
`ifdef STALL_PERF_CNT_EN
        n_tests++;
        if (bus.StallCycles !== 4'd2) begin
            n_fail++;
            $display("FAIL dual_cnt: got %0d required 2", bus.StallCycles);
        end
`endif
        step();
        // EX load and MEM ALU both match: EX wins -> HOLD
        drive(1, 1, 0, 6, 0, 6, 1, 1, 6, 1, 0);
        step();
        n_tests++;
        if (bus.StallState !== 1'b1) begin
            n_fail++;
            $display("FAIL prec_ex_load: state=%b required 1", bus.StallState);
        end
        clear_in();
        step();
        // EX ALU and MEM load both match: single cycle, no HOLD
        drive(1, 1, 0, 6, 0, 6, 1, 0, 6, 1, 1);
        @(negedge clk);
        n_tests++;
        if (bus.Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL prec_ex_alu: stall=%b required 1", bus.Stall);
        end
        step();
        n_tests++;
        if (bus.StallState !== 1'b0) begin
            n_fail++;
            $display("FAIL prec_ex_alu_state: state=%b required 0", bus.StallState);
        end
        clear_in();
        $display("[TB] test_dual_and_precedence: done");
        step();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        drive(1, 1, 0, 5, 0, 5, 1, 1, 0, 0, 0);
        step();
        n_tests++;
        if (bus.StallState !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_enter: state=%b required 1", bus.StallState);
        end
        reset = 1'b1;
        clear_in();
        step();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.StallState !== 1'b0 || bus.Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold_exit: state=%b stall=%b required 0 0",
                     bus.StallState, bus.Stall);
        end
`ifdef STALL_PERF_CNT_EN
        n_tests++;
        if (bus.StallCycles !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_hold_cnt: got %0d required 0", bus.StallCycles);
        end
`endif
        $display("[TB] test_reset_in_hold: state=%b", bus.StallState);
        step();
    endtask

`ifdef STALL_PERF_CNT_EN
    task automatic test_saturation();
        do_reset();
        // persistent ALU->branch hazard stalls every cycle
        drive(1, 0, 1, 0, 7, 7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step();
        n_tests++;
        if (bus.StallCycles !== 4'd14) begin
            n_fail++;
            $display("FAIL sat_pre: got %0d required 14", bus.StallCycles);
        end
        for (int i = 0; i < 5; i++) step();
        n_tests++;
        if (bus.StallCycles !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d required 15", bus.StallCycles);
        end
        clear_in();
        step();
        n_tests++;
        if (bus.StallCycles !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_idle: got %0d required 15", bus.StallCycles);
        end
        $display("[TB] test_saturation: cnt=%0d", bus.StallCycles);
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_in();
        test_reset();
        test_load_branch();
        test_alu_branch();
        test_mem_load_branch();
        test_load_use();
        test_reg_zero();
        test_dual_and_precedence();
        test_reset_in_hold();
`ifdef STALL_PERF_CNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_stall_unit.md
Name: branch_stall_unit

Overview:
- Producer-side companion to the MEM→ID branch forwarding path.
- Detects RAW hazards that MEM→ID forwarding cannot cover: branch sources produced by an instruction still in EX, or by a load in EX/MEM, plus the generic load-use case.
- Holds PC and IF/ID and injects ID/EX bubbles for the exact number of cycles needed.
- Sits in the ID stage next to the forwarding logic. A small FSM guarantees the second stall cycle of a load→branch hazard.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- id_Branch  in  1  ID instruction is a branch/jr that compares registers in ID.
- id_UseRa  in  1  ID instruction reads Ra.
- id_UseRb  in  1  ID instruction reads Rb.
- id_Ra  in  REG_AW  ID source A.
- id_Rb  in  REG_AW  ID source B.
- ex_Rw  in  REG_AW  EX destination.
- ex_RegWr  in  1  EX writes a register.
- ex_MemtoReg  in  1  EX instruction is a load.
- mem_Rw  in  REG_AW  MEM destination.
- mem_RegWr  in  1  MEM writes a register.
- mem_MemtoReg  in  1  MEM instruction is a load.
- Stall  out  1  hold PC and IF/ID (PCWr = IFIDWr = ~Stall).
- Bubble  out  1  zero ID/EX control signals this cycle.
- StallState  out  1  0 = IDLE, 1 = HOLD.
- StallCycles  out  CNT_W  stall cycle count (present only with the optional feature).

Behaviour:
- Match terms, where x ∈ {a, b}:
  - exA = ex_RegWr & (ex_Rw != 0) & (ex_Rw == id_Ra) & id_UseRa; exB is the same with Rb.
  - memA / memB are the same with the mem_* signals.
  - exM = exA | exB; memM = memA | memB.
- Need (combinational, evaluated only in IDLE):
  - need2 = id_Branch & ex_MemtoReg & exM.
  - need1 = id_Branch & ~ex_MemtoReg & exM, OR id_Branch & mem_MemtoReg & memM, OR ~id_Branch & ex_MemtoReg & exM.
  - A non-branch with an ALU producer in EX or MEM needs no stall, because EX forwarding handles it.
- FSM, state register updates on posedge clk:
  - IDLE: Stall = Bubble = need1 | need2. On need2, go to HOLD; otherwise stay in IDLE. need1 needs no extra state; the next IDLE evaluation sees the producer in MEM and either releases or re-stalls.
  - HOLD: Stall = Bubble = 1 unconditionally, inputs ignored. Go to IDLE next cycle.
- Latency:
  - Stall is combinational in the detect cycle.
  - A load→branch hazard yields exactly 2 consecutive Stall cycles.
  - ALU→branch (EX) and load→branch (MEM) yield 1 cycle.
  - Load-use on a non-branch yields 1 cycle.
- Register 0 never matches. Rw == 0 with RegWr = 1 must not stall.
- Ra == Rb, both matching: same result as a single match, no double count.
- When EX and MEM both match, EX takes precedence (need2 if EX is a load).
- Reset:
  - Synchronous. Next edge forces IDLE.
  - Outputs: StallState = 0, and StallCycles = 0 if present.
  - Stall and Bubble follow IDLE combinational rules after reset; both are 0 while no hazard is present.
  - Reset asserted during HOLD: HOLD is abandoned at that edge and the second stall cycle is not produced.

Optional Feature:
- STALL_PERF_CNT_EN
- Defined:
  - StallCycles register is present.
  - Increments by 1 on every clk edge where Stall == 1 and reset == 0.
  - Saturates at all-ones (no wrap).
  - Cleared by reset.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- ex: lw Rw=5, RegWr=1, MemtoReg=1; id: beq Ra=5, UseRa=1, Branch=1 → Stall/Bubble = 1 for 2 cycles (StallState 0→1→0). With STALL_PERF_CNT_EN, StallCycles = 2.
- ex: add Rw=7, MemtoReg=0; id: beq Rb=7, UseRb=1 → Stall = 1 for 1 cycle, StallState stays 0. Next cycle the producer is in MEM ALU → Stall = 0.
- mem: lw Rw=3, MemtoReg=1; id: bne Ra=3 → 1 stall cycle. mem: add Rw=3 (non-load) → Stall = 0.
- ex: lw Rw=4; id: add Ra=4, Branch=0 → 1 stall. ex: add Rw=4, Branch=0 → Stall = 0. Rw=0, Ra=0, RegWr=1 → Stall = 0 in all cases.
- Load→branch hazard, reset = 1 on the cycle after detection (StallState = 1) → next edge StallState = 0, StallCycles = 0, no further Stall with hazard inputs cleared.
- Feature on: force 2^CNT_W+3 stall cycles (CNT_W = 4 build) → StallCycles holds at 15, no wrap.
